// File: rtl/dout_nibble_serializer_if.sv
// Stream-side and pin-side signals of the nibble serializer.
//   D_out_0_din / D_out_0_write / D_out_0_full_n : stream 0 (ap_fifo style)
//   D_out_1_din / D_out_1_write / D_out_1_full_n : stream 1 (ap_fifo style)
//   data_out / data_valid : framed nibble stream towards the pins
//   probe_out             : running XOR parity of emitted data nibbles
//   overflow              : sticky, a write was dropped on a full FIFO
// master = producer/observer side, slave = serializer side.
interface dout_nibble_serializer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] D_out_0_din;
    logic              D_out_0_write;
    logic              D_out_0_full_n;
    logic [DATA_W-1:0] D_out_1_din;
    logic              D_out_1_write;
    logic              D_out_1_full_n;
    logic [3:0]        data_out;
    logic              data_valid;
    logic              probe_out;
    logic              overflow;

    modport master (
        output D_out_0_din, D_out_0_write, D_out_1_din, D_out_1_write,
        input  D_out_0_full_n, D_out_1_full_n,
        input  data_out, data_valid, probe_out, overflow
    );

    modport slave (
        input  D_out_0_din, D_out_0_write, D_out_1_din, D_out_1_write,
        output D_out_0_full_n, D_out_1_full_n,
        output data_out, data_valid, probe_out, overflow
    );
endinterface

// File: rtl/dout_nibble_serializer.sv
// Buffers the two output streams of the gemm core in small FIFOs, picks words
// round-robin and sends each as a header nibble {3'b101, ch} followed by
// DATA_W/4 data nibbles, least significant first.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rst  : synchronous active-high reset
//   bus     : dout_nibble_serializer_if.slave (streams in, nibble stream out)
//
// state | meaning
// IDLE  | nothing on data_out; waiting for a non-empty FIFO
// HDR   | header nibble of the current word is on data_out
// DATA  | data nibble nib_cnt_q of the current word is on data_out
module dout_nibble_serializer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    dout_nibble_serializer_if.slave   bus
);
    localparam int NIB = DATA_W / 4;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int NCW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [NCW-1:0]    nib_cnt_q;
    logic              rr_q;
    logic [3:0]        dout_q;
    logic              valid_q;
    logic              parity_q;
    logic              overflow_q;

    logic [1:0]          wr_en;
    logic [2*DATA_W-1:0] wr_data;
    logic [2*DATA_W-1:0] rd_data;
    logic [1:0]          non_empty;
    logic [1:0]          not_full;
    logic [1:0]          pop;

    logic              sel_ch;
    logic              arb_slot;
    logic              pop_en;
    logic [DATA_W-1:0] pop_word;
    logic              last_nib;

    assign wr_en   = {bus.D_out_1_write, bus.D_out_0_write};
    assign wr_data = {bus.D_out_1_din, bus.D_out_0_din};

    for (genvar c = 0; c < 2; c++) begin : g_fifo
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]     wr_ptr_q;
        logic [AW-1:0]     rd_ptr_q;
        logic [CW-1:0]     cnt_q;
        logic [CW-1:0]     cnt_d;
        logic              wr_ok;

        // Room is judged on the count at the start of the cycle, so a pop in
        // the same cycle never frees a slot for the incoming write.
        assign wr_ok = wr_en[c] && (cnt_q != CW'(FIFO_DEPTH));

        always_comb begin
            cnt_d = cnt_q;
            if (wr_ok && !pop[c]) cnt_d = cnt_q + CW'(1);
            if (!wr_ok && pop[c]) cnt_d = cnt_q - CW'(1);
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (wr_ok)  wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop[c]) rd_ptr_q <= rd_ptr_q + AW'(1);
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge ap_clk) begin
            if (wr_ok) mem_q[wr_ptr_q] <= wr_data[c*DATA_W +: DATA_W];
        end

        assign rd_data[c*DATA_W +: DATA_W] = mem_q[rd_ptr_q];
        assign non_empty[c] = (cnt_q != '0);
        assign not_full[c]  = (cnt_q != CW'(FIFO_DEPTH));
    end

    // Both candidates: follow the pointer. One candidate: it wins outright.
    assign sel_ch   = (non_empty[0] && non_empty[1]) ? rr_q : non_empty[1];
    assign last_nib = (nib_cnt_q == NCW'(NIB - 1));
    assign arb_slot = (state_q == S_IDLE) || ((state_q == S_DATA) && last_nib);
    assign pop_en   = arb_slot && (non_empty != 2'b00);
    assign pop      = pop_en ? (sel_ch ? 2'b10 : 2'b01) : 2'b00;
    assign pop_word = sel_ch ? rd_data[DATA_W +: DATA_W] : rd_data[0 +: DATA_W];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            nib_cnt_q <= '0;
            rr_q      <= 1'b0;
            dout_q    <= 4'h0;
            valid_q   <= 1'b0;
            parity_q  <= 1'b0;
        end else if (pop_en) begin
            // Covers both IDLE and the last data nibble: header goes out next.
            state_q   <= S_HDR;
            shift_q   <= pop_word;
            rr_q      <= ~sel_ch;
            dout_q    <= {3'b101, sel_ch};
            valid_q   <= 1'b1;
        end else begin
            case (state_q)
                S_HDR: begin
                    state_q   <= S_DATA;
                    nib_cnt_q <= '0;
                    dout_q    <= shift_q[3:0];
                    shift_q   <= shift_q >> 4;
                    parity_q  <= parity_q ^ (^shift_q[3:0]);
                    valid_q   <= 1'b1;
                end
                S_DATA: begin
                    if (last_nib) begin
                        state_q <= S_IDLE;
                        dout_q  <= 4'h0;
                        valid_q <= 1'b0;
                    end else begin
                        nib_cnt_q <= nib_cnt_q + NCW'(1);
                        dout_q    <= shift_q[3:0];
                        shift_q   <= shift_q >> 4;
                        parity_q  <= parity_q ^ (^shift_q[3:0]);
                        valid_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    dout_q  <= 4'h0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            overflow_q <= 1'b0;
        end else if ((wr_en & ~not_full) != 2'b00) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.D_out_0_full_n = not_full[0];
    assign bus.D_out_1_full_n = not_full[1];
    assign bus.data_out       = dout_q;
    assign bus.data_valid     = valid_q;
    assign bus.probe_out      = parity_q;
    assign bus.overflow       = overflow_q;
endmodule
